// File: rtl/my_pulse_arbiter.sv
// Round-robin arbiter for asynchronous request levels: each channel's rising edge raises a pending flag,
// and the shared resource is then granted for 1+HOLD_CYCLES clocks. Define MY_PULSE_ARBITER_OVF_EN to add sticky overflow flags.
module my_pulse_arbiter #(
  parameter int N_REQ       = 4,
  parameter int SYNC_LEN    = 3,
  parameter int HOLD_CYCLES = 8
) (
  input  logic             clk_in,
  input  logic             clr_n_in,
  input  logic [N_REQ-1:0] d_in,
  output logic [N_REQ-1:0] gnt_out,
  output logic             busy_out,
  output logic [N_REQ-1:0] pend_out
`ifdef MY_PULSE_ARBITER_OVF_EN
  ,
  output logic [N_REQ-1:0] ovf_out
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_HOLD
  } state_t;

  logic [1:0]                        rst_sync;
  logic                              rst_n;
  logic [N_REQ-1:0][SYNC_LEN-1:0]    stage;
  logic [N_REQ-1:0]                  rise;
  logic [N_REQ-1:0]                  pend;
  logic [N_REQ-1:0]                  win_mask;
  logic [N_REQ-1:0]                  clr_mask;
  logic [IDX_W-1:0]                  win_idx;
  logic [IDX_W-1:0]                  last;
  logic                              win_found;
  logic [7:0]                        cnt;
  state_t                            state;

  // NOTE: reset asserts asynchronously but releases two clocks later, so no flop leaves reset on a
  // clock edge that races the release; sequential state always uses non-blocking assignment.
  always_ff @(posedge clk_in or negedge clr_n_in) begin
    if (!clr_n_in) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) stage[i] <= {stage[i][SYNC_LEN-2:0], d_in[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) rise[i] = stage[i][SYNC_LEN-2] & ~stage[i][SYNC_LEN-1];
  end

  // Round-robin search starting just above the most recently granted channel.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last;
    win_mask  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int c;
      c = (int'(last) + k) % N_REQ;
      if (!win_found && pend[c]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(c);
      end
    end
    if (win_found) win_mask[win_idx] = 1'b1;
  end

  assign clr_mask = (state == S_IDLE) ? win_mask : '0;

  // A new edge wins over the grant-time clear, so a re-request during its own grant is kept.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~clr_mask) | rise;
  end

  assign pend_out = pend;

`ifdef MY_PULSE_ARBITER_OVF_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) ovf_out <= '0;
    else        ovf_out <= ovf_out | (rise & pend & ~clr_mask);
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      last     <= IDX_W'(N_REQ - 1);
      cnt      <= '0;
      gnt_out  <= '0;
      busy_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            state    <= S_GRANT;
            gnt_out  <= win_mask;
            busy_out <= 1'b1;
            last     <= win_idx;
            cnt      <= 8'(HOLD_CYCLES - 1);
          end
        end
        S_GRANT: begin
          gnt_out <= '0;
          state   <= S_HOLD;
        end
        S_HOLD: begin
          if (cnt == 8'd0) begin
            state    <= S_IDLE;
            busy_out <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          gnt_out  <= '0;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_pulse_arbiter.sv
// Self-checking bench for my_pulse_arbiter: directed scenarios plus randomized request levels,
// checked every cycle against an event-level reference model (rise events, latency, round-robin pick).
module tb_my_pulse_arbiter;

  localparam int N = 4;
  localparam int S = 3;
  localparam int H = 8;

  logic         clk_in = 1'b0;
  logic         clr_n_in;
  logic [N-1:0] d_in;
  logic [N-1:0] gnt_out;
  logic         busy_out;
  logic [N-1:0] pend_out;
`ifdef MY_PULSE_ARBITER_OVF_EN
  logic [N-1:0] ovf_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  my_pulse_arbiter #(.N_REQ(N), .SYNC_LEN(S), .HOLD_CYCLES(H)) dut (
    .clk_in   (clk_in),
    .clr_n_in (clr_n_in),
    .d_in     (d_in),
    .gnt_out  (gnt_out),
    .busy_out (busy_out),
    .pend_out (pend_out)
`ifdef MY_PULSE_ARBITER_OVF_EN
    ,
    .ovf_out  (ovf_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    int ch;
  } rise_t;

  rise_t        rq[$];
  logic [N-1:0] m_prev;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_gnt;
  logic [N-1:0] m_ovf;
  int           m_last;
  int           m_busy_left;
  int           m_rel;
  int           m_cyc;

  task automatic model_clear();
    rq.delete();
    m_prev      = '0;
    m_pend      = '0;
    m_gnt       = '0;
    m_ovf       = '0;
    m_last      = N - 1;
    m_busy_left = 0;
    m_rel       = 0;
    m_cyc       = 0;
  endtask

  // A 0->1 change between consecutive samples becomes a pending request S-1 clocks later.
  task automatic model_step(input logic [N-1:0] d);
    logic [N-1:0] due_now;
    logic [N-1:0] take;
    int           win;
    due_now = '0;
    take    = '0;
    win     = -1;
    while (rq.size() > 0 && rq[0].due == m_cyc) begin
      due_now[rq[0].ch] = 1'b1;
      void'(rq.pop_front());
    end
    if (m_busy_left == 0 && m_pend != '0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (win < 0 && m_pend[c]) win = c;
      end
    end
    m_gnt = '0;
    if (m_busy_left > 0) m_busy_left--;
    if (win >= 0) begin
      take[win]   = 1'b1;
      m_gnt[win]  = 1'b1;
      m_last      = win;
      m_busy_left = 1 + H;
    end
    m_ovf  = m_ovf | (due_now & m_pend & ~take);
    m_pend = (m_pend & ~take) | due_now;
    for (int ch = 0; ch < N; ch++) begin
      if (d[ch] && !m_prev[ch]) rq.push_back('{due: m_cyc + S - 1, ch: ch});
    end
    m_prev = d;
    m_cyc++;
  endtask

  // The design ignores the first two clocks after reset release.
  always @(posedge clk_in or negedge clr_n_in) begin
    if (!clr_n_in)      model_clear();
    else if (m_rel < 2) m_rel++;
    else                model_step(d_in);
  end

  always @(negedge clk_in) begin
    check("gnt", gnt_out, m_gnt);
    check("busy", busy_out, m_busy_left > 0);
    check("pend", pend_out, m_pend);
`ifdef MY_PULSE_ARBITER_OVF_EN
    check("ovf", ovf_out, m_ovf);
`endif
  end

  // ---------------- stimulus helpers ----------------
  int g_ch[$];
  int g_t[$];

  task automatic drive(input logic [N-1:0] v);
    #1;
    d_in = v;
  endtask

  // Called just after a falling edge; leaves the design out of reset and sampling.
  task automatic do_reset(input logic [N-1:0] dval);
    #1;
    clr_n_in = 1'b0;
    d_in     = dval;
    #1;
    check("rst_gnt", gnt_out, '0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_pend", pend_out, '0);
    @(negedge clk_in);
    #1;
    clr_n_in = 1'b1;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic collect(input int n);
    g_ch.delete();
    g_t.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk_in);
      if (gnt_out != '0) begin
        int ch;
        ch = -1;
        for (int k = 0; k < N; k++) if (gnt_out[k]) ch = k;
        g_ch.push_back(ch);
        g_t.push_back(c);
      end
    end
  endtask

  function automatic int q_at(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  initial begin
    int           busy_n;
    int           gnt_n;
    logic [N-1:0] v;

    clr_n_in = 1'b1;
    d_in     = '0;
    model_clear();
    do_reset('0);

    // Quiet inputs: nothing may happen.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      check("idle_gnt", gnt_out, '0);
      check("idle_busy", busy_out, 1'b0);
      check("idle_pend", pend_out, '0);
    end

    // Single request on channel 2: minimum latency and busy length.
    drive(4'b0100);
    repeat (2) @(negedge clk_in);
    check("lat_pend_e1", pend_out, '0);
    @(negedge clk_in);
    check("lat_pend_e2", pend_out, 4'b0100);
    check("lat_nogr_e2", gnt_out, '0);
    @(negedge clk_in);
    check("lat_gnt_e3", gnt_out, 4'b0100);
    busy_n = 0;
    gnt_n  = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk_in);
      busy_n += int'(busy_out);
      gnt_n  += int'(gnt_out != '0);
    end
    check("lat_busy_len", busy_n, 1 + H);
    check("lat_gnt_cnt", gnt_n, 1);
    drive('0);

    // All four rise together: granted 0..3, spaced by busy length plus one idle clock.
    @(negedge clk_in);
    do_reset('0);
    drive(4'b1111);
    collect(60);
    check("rr4_count", g_ch.size(), 4);
    check("rr4_first_t", q_at(g_t, 0), 3);
    for (int k = 0; k < 4; k++) begin
      check("rr4_order", q_at(g_ch, k), k);
      if (k > 0) check("rr4_spacing", q_at(g_t, k) - q_at(g_t, k - 1), 2 + H);
    end
    drive('0);

    // Channel 1 granted, then 0 and 3 arrive during hold: wrap order 3 then 0.
    @(negedge clk_in);
    do_reset('0);
    drive(4'b0010);
    collect(6);
    check("wrap_first", q_at(g_ch, 0), 1);
    drive(4'b1011);
    collect(30);
    check("wrap_count", g_ch.size(), 2);
    check("wrap_next", q_at(g_ch, 0), 3);
    check("wrap_then", q_at(g_ch, 1), 0);
    check("wrap_spacing", q_at(g_t, 1) - q_at(g_t, 0), 2 + H);

    // Reset pulse during hold aborts the grant; no grant afterwards without a new edge.
    @(negedge clk_in);
    do_reset('0);
    drive(4'b0100);
    collect(8);
    check("abort_pre_gnt", q_at(g_ch, 0), 2);
    check("abort_pre_busy", busy_out, 1'b1);
    do_reset('0);
    collect(30);
    check("abort_no_gnt", g_ch.size(), 0);

    // Level held high across reset release yields exactly one grant.
    @(negedge clk_in);
    do_reset(4'b0001);
    collect(40);
    check("hold_rel_count", g_ch.size(), 1);
    check("hold_rel_ch", q_at(g_ch, 0), 0);
    drive('0);

`ifdef MY_PULSE_ARBITER_OVF_EN
    // Two edges on channel 1 during channel 0's hold: one grant, sticky overflow.
    @(negedge clk_in);
    do_reset('0);
    drive(4'b0001);
    collect(4);
    check("ovf_pre_gnt", q_at(g_ch, 0), 0);
    drive(4'b0011);
    repeat (2) @(negedge clk_in);
    drive(4'b0001);
    repeat (2) @(negedge clk_in);
    drive(4'b0011);
    collect(25);
    check("ovf_gnt_count", g_ch.size(), 1);
    check("ovf_gnt_ch", q_at(g_ch, 0), 1);
    check("ovf_flag", ovf_out, 4'b0010);
    drive('0);
    repeat (30) @(negedge clk_in);
    check("ovf_sticky", ovf_out, 4'b0010);
`endif

    // Random request levels with occasional one-clock resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_in);
      #1;
      if (!clr_n_in) clr_n_in = 1'b1;
      else if ($urandom_range(0, 249) == 0) clr_n_in = 1'b0;
      v = d_in;
      for (int ch = 0; ch < N; ch++) if ($urandom_range(0, 4) == 0) v[ch] = ~v[ch];
      d_in = v;
    end
    @(negedge clk_in);
    #1;
    clr_n_in = 1'b1;
    repeat (3) @(negedge clk_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
